// File: rtl/pdm_decimator.sv
// 3rd-order CIC decimator: 1-bit PDM stream in, DATA_BITS-wide PCM samples out.
// Optional two's-complement output when PDM_DECIMATOR_SIGNED_EN is defined.
module pdm_decimator #(
  parameter int unsigned DATA_BITS     = 12,
  parameter int unsigned DECIM_LOG2    = 6,
  parameter int unsigned WARMUP_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 pdm_in,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid
);

  localparam int unsigned CW = 3 * DECIM_LOG2;
  localparam int unsigned W  = CW + 1;
  localparam int unsigned FW = (WARMUP_FRAMES > 0) ? $clog2(WARMUP_FRAMES + 1) : 1;

  localparam logic [W-1:0]  FULL_SCALE = {1'b1, {CW{1'b0}}};
  localparam logic [FW-1:0] WARM_LAST  = FW'(WARMUP_FRAMES);

  logic [W-1:0]            int1;
  logic [W-1:0]            int2;
  logic [W-1:0]            int3;
  logic [W-1:0]            int3_nxt;
  logic [DECIM_LOG2-1:0]   dec_cnt;
  logic                    dec_last;
  logic                    dec_stb;
  logic [W-1:0]            samp;
  logic [W-1:0]            s_d;
  logic [W-1:0]            c1_d;
  logic [W-1:0]            c2_d;
  logic [W-1:0]            c1;
  logic [W-1:0]            c2;
  logic [W-1:0]            c3;
  logic [FW-1:0]           fcnt;
  logic                    warm;
  logic [DATA_BITS-1:0]    scaled;
  logic [DATA_BITS-1:0]    dout_nxt;

  // Integrator section: modulo-2^W, wrap is expected and cancelled by the combs.
  always_comb begin
    int3_nxt = int3 + int2;
    dec_last = (dec_cnt == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1    <= '0;
      int2    <= '0;
      int3    <= '0;
      dec_cnt <= '0;
    end else if (en) begin
      int1    <= int1 + W'(pdm_in);
      int2    <= int2 + int1;
      int3    <= int3_nxt;
      dec_cnt <= dec_cnt + 1'b1;
    end
  end

  // Decimation point: capture the integrator value being written on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_stb <= 1'b0;
      samp    <= '0;
    end else begin
      dec_stb <= en && dec_last;
      if (en && dec_last) begin
        samp <= int3_nxt;
      end
    end
  end

  // Comb section runs at the decimated rate, regardless of en.
  always_comb begin
    c1 = samp - s_d;
    c2 = c1 - c1_d;
    c3 = c2 - c2_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d  <= '0;
      c1_d <= '0;
      c2_d <= '0;
    end else if (dec_stb) begin
      s_d  <= samp;
      c1_d <= c1;
      c2_d <= c2;
    end
  end

  // Output scaling: an all-ones frame is the single value that does not fit.
  always_comb begin
    scaled = (c3 == FULL_SCALE) ? '1 : c3[CW-1 -: DATA_BITS];
`ifdef PDM_DECIMATOR_SIGNED_EN
    dout_nxt = scaled ^ (DATA_BITS'(1) << (DATA_BITS - 1));
`else
    dout_nxt = scaled;
`endif
  end

  // Warmup: the first WARMUP_FRAMES comb results only prime the delay line.
  always_comb begin
    warm = (fcnt < WARM_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
    end else if (dec_stb && warm) begin
      fcnt <= fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= dec_stb && !warm;
      if (dec_stb && !warm) begin
        dout <= dout_nxt;
      end
    end
  end

endmodule
